m_sram_arb: RTL and testbench

- Two-master Wishbone arbiter and sequencer for the external 16-bit asynchronous SRAM.
- Master 0 is the midgetv core data/instruction port; master 1 is the loader/debug port.
- Each 32-bit Wishbone word access is split into two 16-bit SRAM cycles with programmable wait states.
- All SRAM strobes are generated from registers.

---
 rtl/m_sram_pkg.sv | 22 ++
 rtl/m_rr_arb2.sv | 28 ++
 rtl/m_sram_arb.sv | 180 ++++++++++++++++++
 tb/tb_m_sram_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_sram_pkg.sv
// Shared definitions for the two-master SRAM arbiter: FSM state encoding,
// default wait-state count and the idle value of the active-low strobe group.
package m_sram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam int WAITST_DEF = 1;

  typedef struct packed {
    logic cs_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
  } strb_t;

  localparam strb_t STRB_IDLE = 5'b11111;

endpackage

// File: rtl/m_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, zero latency; the last-grant
// flop only moves when en is high, and a losing request simply waits (no timeout).
module m_rr_arb2
  import m_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       vld,
  output logic       idx
);

  logic last;

  always_comb begin
    vld = |req;
    if (req == 2'b11) idx = ~last;
    else              idx = req[1];
  end

  // last resets to 1 so that the first contested grant goes to master 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last <= 1'b1;
    else if (en && vld)  last <= idx;
  end

endmodule

// File: rtl/m_sram_arb.sv
// Two-master Wishbone arbiter/sequencer for a 16-bit async SRAM; a word access takes
// two registered halfword phases of WAITST+1 cycles each, then one ACK cycle; losers wait.
module m_sram_arb
  import m_sram_pkg::*;
#(
  parameter int SRAMADRWIDTH = 16,
  parameter int WAITST       = WAITST_DEF
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    m0_CYC_I,
  input  logic                    m0_STB_I,
  input  logic                    m0_WE_I,
  input  logic [3:0]              m0_SEL_I,
  input  logic [SRAMADRWIDTH-2:0] m0_ADR_I,
  input  logic [31:0]             m0_DAT_I,
  output logic                    m0_ACK_O,
  input  logic                    m1_CYC_I,
  input  logic                    m1_STB_I,
  input  logic                    m1_WE_I,
  input  logic [3:0]              m1_SEL_I,
  input  logic [SRAMADRWIDTH-2:0] m1_ADR_I,
  input  logic [31:0]             m1_DAT_I,
  output logic                    m1_ACK_O,
  output logic [31:0]             DAT_O,
  output logic                    gnt,
  output logic [SRAMADRWIDTH-1:0] sram_a,
  output logic [15:0]             sram_d_o,
  input  logic [15:0]             sram_d_i,
  output logic                    sram_d_oe,
  output logic                    sram_cs_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic                    sram_lb_n,
  output logic                    sram_ub_n
);

  localparam int         AW      = SRAMADRWIDTH - 1;
  localparam logic [2:0] PH_LAST = 3'(WAITST);

  logic [1:0]              state, state_nxt;
  logic [2:0]              phase, phase_nxt;
  logic                    abort_q, abort_nxt;
  logic [AW-1:0]           adr_q, adr_nxt;
  logic                    we_q, we_nxt;
  logic [3:0]              sel_q, sel_nxt;
  logic [31:0]             dat_q, dat_nxt;
  logic                    gnt_nxt;
  logic [1:0]              req;
  logic                    arb_vld, arb_idx;
  logic                    own_cyc, phase_end, hi_nxt;
  strb_t                   strb_q, strb_nxt;
  logic                    d_oe_nxt;
  logic [15:0]             d_o_nxt;
  logic [SRAMADRWIDTH-1:0] a_nxt;

  assign req       = {m1_CYC_I & m1_STB_I, m0_CYC_I & m0_STB_I};
  assign own_cyc   = gnt ? m1_CYC_I : m0_CYC_I;
  assign phase_end = (phase == PH_LAST);

  m_rr_arb2 u_arb (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .en    (state == ST_IDLE),
    .req   (req),
    .vld   (arb_vld),
    .idx   (arb_idx)
  );

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    abort_nxt = abort_q;
    adr_nxt   = adr_q;
    we_nxt    = we_q;
    sel_nxt   = sel_q;
    dat_nxt   = dat_q;
    gnt_nxt   = gnt;
    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_nxt   = arb_idx;
          adr_nxt   = arb_idx ? m1_ADR_I : m0_ADR_I;
          we_nxt    = arb_idx ? m1_WE_I  : m0_WE_I;
          sel_nxt   = arb_idx ? m1_SEL_I : m0_SEL_I;
          dat_nxt   = arb_idx ? m1_DAT_I : m0_DAT_I;
          abort_nxt = 1'b0;
          phase_nxt = 3'd0;
          if (we_nxt && sel_nxt == 4'd0)           state_nxt = ST_ACK;
          else if (we_nxt && sel_nxt[1:0] == 2'd0) state_nxt = ST_HI;
          else                                     state_nxt = ST_LO;
        end
      end
      ST_LO, ST_HI: begin
        // a dropped CYC is remembered but the phase still runs to its end
        abort_nxt = abort_q | ~own_cyc;
        if (phase_end) begin
          phase_nxt = 3'd0;
          if (abort_nxt)                               state_nxt = ST_IDLE;
          else if (state == ST_HI)                     state_nxt = ST_ACK;
          else if (we_q && sel_q[3:2] == 2'd0)         state_nxt = ST_ACK;
          else                                         state_nxt = ST_HI;
        end else begin
          phase_nxt = phase + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // strobes are derived from the next state so every SRAM pin comes straight from a flop
  always_comb begin
    strb_nxt = STRB_IDLE;
    d_oe_nxt = 1'b0;
    d_o_nxt  = sram_d_o;
    a_nxt    = sram_a;
    hi_nxt   = (state_nxt == ST_HI);
    if (state_nxt == ST_LO || state_nxt == ST_HI) begin
      a_nxt         = {adr_nxt, hi_nxt};
      strb_nxt.cs_n = 1'b0;
      if (we_nxt) begin
        d_oe_nxt      = 1'b1;
        d_o_nxt       = hi_nxt ? dat_nxt[31:16] : dat_nxt[15:0];
        strb_nxt.we_n = (phase_nxt == 3'd0);
        strb_nxt.lb_n = ~(hi_nxt ? sel_nxt[2] : sel_nxt[0]);
        strb_nxt.ub_n = ~(hi_nxt ? sel_nxt[3] : sel_nxt[1]);
      end else begin
        strb_nxt.oe_n = 1'b0;
        strb_nxt.lb_n = 1'b0;
        strb_nxt.ub_n = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state     <= ST_IDLE;
      phase     <= 3'd0;
      abort_q   <= 1'b0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      gnt       <= 1'b0;
      strb_q    <= STRB_IDLE;
      sram_d_oe <= 1'b0;
      sram_d_o  <= 16'd0;
      sram_a    <= '0;
      m0_ACK_O  <= 1'b0;
      m1_ACK_O  <= 1'b0;
      DAT_O     <= 32'd0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      abort_q   <= abort_nxt;
      adr_q     <= adr_nxt;
      we_q      <= we_nxt;
      sel_q     <= sel_nxt;
      dat_q     <= dat_nxt;
      gnt       <= gnt_nxt;
      strb_q    <= strb_nxt;
      sram_d_oe <= d_oe_nxt;
      sram_d_o  <= d_o_nxt;
      sram_a    <= a_nxt;
      m0_ACK_O  <= (state_nxt == ST_ACK) && !gnt_nxt;
      m1_ACK_O  <= (state_nxt == ST_ACK) &&  gnt_nxt;
      if ((state == ST_LO || state == ST_HI) && !we_q && phase_end) begin
        if (state == ST_HI) DAT_O[31:16] <= sram_d_i;
        else                DAT_O[15:0]  <= sram_d_i;
      end
    end
  end

  assign sram_cs_n = strb_q.cs_n;
  assign sram_oe_n = strb_q.oe_n;
  assign sram_we_n = strb_q.we_n;
  assign sram_lb_n = strb_q.lb_n;
  assign sram_ub_n = strb_q.ub_n;

endmodule

// File: tb/tb_m_sram_arb.sv
// Bench for m_sram_arb: behavioural SRAM model, ACK scoreboard and strobe counters.
module tb_m_sram_arb;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        m0_CYC_I, m0_STB_I, m0_WE_I, m0_ACK_O;
  logic [3:0]  m0_SEL_I;
  logic [14:0] m0_ADR_I;
  logic [31:0] m0_DAT_I;
  logic        m1_CYC_I, m1_STB_I, m1_WE_I, m1_ACK_O;
  logic [3:0]  m1_SEL_I;
  logic [14:0] m1_ADR_I;
  logic [31:0] m1_DAT_I;
  logic [31:0] DAT_O;
  logic        gnt;
  logic [15:0] sram_a, sram_d_o, sram_d_i;
  logic        sram_d_oe, sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  m_sram_arb #(.SRAMADRWIDTH(16), .WAITST(1)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
    .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_ACK_O(m0_ACK_O),
    .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
    .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_ACK_O(m1_ACK_O),
    .DAT_O(DAT_O), .gnt(gnt), .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_i(sram_d_i),
    .sram_d_oe(sram_d_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 CLK_I = ~CLK_I;

  // SRAM model: untouched locations read as address ^ 5A5A
  logic [15:0] mem [0:65535];
  bit          wr_vld [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_a = 16'd0, pre_d = 16'd0, wtmp;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return wr_vld[a] ? mem[a] : (a ^ 16'h5A5A);
  endfunction

  assign sram_d_i = (!sram_cs_n && !sram_oe_n) ? rd(sram_a) : 16'h0000;

  always @(posedge CLK_I) begin
    if (pre_en) begin
      mem[pre_a]    <= pre_d;
      wr_vld[pre_a] <= 1'b1;
    end else if (!sram_cs_n && !sram_we_n && sram_d_oe) begin
      wtmp = rd(sram_a);
      if (!sram_lb_n) wtmp[7:0]  = sram_d_o[7:0];
      if (!sram_ub_n) wtmp[15:8] = sram_d_o[15:8];
      mem[sram_a]    <= wtmp;
      wr_vld[sram_a] <= 1'b1;
    end
  end

  int          cyc = 0;
  int          cs_lo = 0, oe_lo = 0, we_lo = 0, setup = 0, dual = 0;
  int          ack_cnt0 = 0, ack_cnt1 = 0, ack_cyc = 0;
  logic        ack_m = 1'b0, ack_gnt = 1'b0;
  logic [31:0] ack_dat = 32'd0;
  logic [1:0]  lanes = 2'b11;

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(negedge CLK_I) begin
    if (!sram_cs_n) cs_lo++;
    if (!sram_cs_n && !sram_oe_n) oe_lo++;
    if (!sram_cs_n && !sram_we_n) begin
      we_lo++;
      lanes = {sram_ub_n, sram_lb_n};
    end
    if (!sram_cs_n && sram_d_oe && sram_we_n) setup++;
    if (m0_ACK_O && m1_ACK_O) dual++;
    if (m0_ACK_O || m1_ACK_O) begin
      if (m1_ACK_O) ack_cnt1++;
      else          ack_cnt0++;
      ack_m   = m1_ACK_O;
      ack_gnt = gnt;
      ack_dat = DAT_O;
      ack_cyc = cyc;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        m;
    logic        rd;
    logic [31:0] dat;
    int          c0;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic drive(input logic m, input logic on, input logic we, input logic [3:0] sel,
                       input logic [14:0] adr, input logic [31:0] dat);
    if (!m) begin
      m0_CYC_I = on; m0_STB_I = on; m0_WE_I = we; m0_SEL_I = sel; m0_ADR_I = adr; m0_DAT_I = dat;
    end else begin
      m1_CYC_I = on; m1_STB_I = on; m1_WE_I = we; m1_SEL_I = sel; m1_ADR_I = adr; m1_DAT_I = dat;
    end
  endtask

  // lat counts cycles from the sampling edge: cycle 1 lies between that edge and the next
  task automatic start(input logic m, input logic we, input logic [3:0] sel, input logic [14:0] adr,
                       input logic [31:0] dat, input int lat, input logic same_edge);
    exp_t e;
    if (!same_edge) begin
      @(posedge CLK_I); #1;
    end
    drive(m, 1'b1, we, sel, adr, dat);
    e.m   = m;
    e.rd  = !we;
    e.dat = {rd({adr, 1'b1}), rd({adr, 1'b0})};
    e.c0  = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output logic m);
    exp_t e;
    int   base;
    base = ack_cnt0 + ack_cnt1;
    m    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK_I); #1;
      if (ack_cnt0 + ack_cnt1 != base) break;
    end
    if (ack_cnt0 + ack_cnt1 == base) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check("ack_unexpected", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      m = ack_m;
      check("ack_owner", 32'(ack_m), 32'(e.m));
      check("ack_gnt", 32'(ack_gnt), 32'(e.m));
      if (e.rd)      check("rd_data", ack_dat, e.dat);
      if (e.lat != 0) check("ack_lat", 32'(ack_cyc - e.c0 + 1), 32'(e.lat));
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(posedge CLK_I); #1;
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(posedge CLK_I); #1;
    pre_en = 1'b0;
  endtask

  function automatic logic [31:0] idle_vec();
    return {23'd0, sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
            sram_d_oe, m1_ACK_O, m0_ACK_O, gnt};
  endfunction

  initial begin
    logic m;
    int   b_cs, b_oe, b_we, b_su, b_a1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);

    repeat (3) @(posedge CLK_I); #1;
    check("rst_idle", idle_vec(), 32'h1F0);
    check("rst_dat", DAT_O, 32'h0);
    check("rst_a", 32'(sram_a), 32'h0);
    RST_I = 1'b1;

    // reset asserted while a write's we_n pulse is active
    @(posedge CLK_I); #1;
    drive(1'b0, 1'b1, 1'b1, 4'hF, 15'h0300, 32'h11112222);
    repeat (2) @(posedge CLK_I); #1;
    check("midwr_doe", 32'(sram_d_oe), 32'd1);
    RST_I = 1'b0; #1;
    check("midrst_idle", idle_vec(), 32'h1F0);
    check("midrst_a", 32'(sram_a), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    repeat (2) @(posedge CLK_I); #1;
    RST_I = 1'b1;
    repeat (3) @(posedge CLK_I); #1;
    check("midrst_noack", 32'(ack_cnt0 + ack_cnt1), 32'd0);

    preload(16'h0246, 16'hBEEF);
    preload(16'h0247, 16'hDEAD);
    preload(16'h0080, 16'h1111);
    preload(16'h0081, 16'h2222);

    b_cs = cs_lo; b_oe = oe_lo; b_we = we_lo;
    start(1'b0, 1'b0, 4'hF, 15'h0123, 32'h0, 5, 1'b0);
    wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    check("rd_word", ack_dat, 32'hDEADBEEF);
    check("rd_we_low", 32'(we_lo - b_we), 32'd0);
    check("rd_cs_cycles", 32'(cs_lo - b_cs), 32'd4);
    check("rd_oe_cycles", 32'(oe_lo - b_oe), 32'd4);

    b_cs = cs_lo; b_we = we_lo; b_su = setup;
    start(1'b1, 1'b1, 4'hF, 15'h0010, 32'hCAFEF00D, 5, 1'b0);
    wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    check("wr_lo", 32'(rd(16'h0020)), 32'hF00D);
    check("wr_hi", 32'(rd(16'h0021)), 32'hCAFE);
    check("wr_setup", 32'(setup - b_su), 32'd2);
    check("wr_we_low", 32'(we_lo - b_we), 32'd2);
    check("wr_cs_cycles", 32'(cs_lo - b_cs), 32'd4);

    b_cs = cs_lo; b_su = setup;
    start(1'b0, 1'b1, 4'h4, 15'h0040, 32'h00AB0000, 3, 1'b0);
    wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    check("bw_hi", 32'(rd(16'h0081)), 32'h22AB);
    check("bw_lo_kept", 32'(rd(16'h0080)), 32'h1111);
    check("bw_lanes", 32'(lanes), 32'h2);
    check("bw_cs_cycles", 32'(cs_lo - b_cs), 32'd2);
    check("bw_setup", 32'(setup - b_su), 32'd1);

    b_cs = cs_lo;
    start(1'b0, 1'b1, 4'h0, 15'h0041, 32'hFFFFFFFF, 1, 1'b0);
    wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    check("sel0_cs_cycles", 32'(cs_lo - b_cs), 32'd0);
    check("sel0_nowrite", 32'(rd(16'h0082)), 32'h5AD8);
    check("dat_hold", DAT_O, 32'hDEADBEEF);

    // fresh reset so the first contested grant goes to m0
    @(posedge CLK_I); #1; RST_I = 1'b0;
    @(posedge CLK_I); #1; RST_I = 1'b1;
    for (int r = 0; r < 2; r++) begin
      start(1'b0, 1'b0, 4'hF, 15'(15'h0200 + 2 * r), 32'h0, 5, 1'b0);
      start(1'b1, 1'b0, 4'hF, 15'(15'h0201 + 2 * r), 32'h0, 11, 1'b1);
      wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
      wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    end

    // m1 abandons a write in its LO phase while m0 is waiting
    b_cs = cs_lo; b_we = we_lo; b_su = setup; b_a1 = ack_cnt1;
    @(posedge CLK_I); #1;
    drive(1'b1, 1'b1, 1'b1, 4'hF, 15'h0050, 32'h77776666);
    @(posedge CLK_I); #1;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    start(1'b0, 1'b0, 4'hF, 15'h0123, 32'h0, 7, 1'b1);
    wait_ack(m); drive(m, 1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    check("abort_lo", 32'(rd(16'h00A0)), 32'h6666);
    check("abort_hi_kept", 32'(rd(16'h00A1)), 32'h5AFB);
    check("abort_we_low", 32'(we_lo - b_we), 32'd1);
    check("abort_setup", 32'(setup - b_su), 32'd1);
    check("abort_cs_cycles", 32'(cs_lo - b_cs), 32'd6);
    check("abort_no_ack", 32'(ack_cnt1 - b_a1), 32'd0);

    repeat (4) @(posedge CLK_I); #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("dual_ack", 32'(dual), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
